// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (transmitter and the
// scan-code receiver that sits on the same pins).
//   - ps2TxState_e   : state encoding of the host-to-device transmitter
//   - PS2_CMD_*      : common host command bytes
//   - PS2_DEFAULT_*  : default timing, in system clock cycles at 50 MHz
//   - ps2OddParity() : parity bit that makes the 9-bit frame odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        PS2_TX_IDLE      = 3'd0,
        PS2_TX_INHIBIT   = 3'd1,
        PS2_TX_START     = 3'd2,
        PS2_TX_SHIFT     = 3'd3,
        PS2_TX_WAIT_IDLE = 3'd4
    } ps2TxState_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // 100 us of clock inhibit and a 15 ms inter-edge watchdog at 50 MHz
    localparam int unsigned PS2_DEFAULT_INHIBIT_CYCLES = 5000;
    localparam int unsigned PS2_DEFAULT_TIMEOUT_CYCLES = 750000;

    // Odd parity: the bit is set when the byte holds an even number of ones
    function automatic logic ps2OddParity(input logic [7:0] byteIn);
        return ~^byteIn;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Brings the asynchronous PS/2 clock and data pins into the clk_i domain
// with two flops each and flags falling edges of the synchronized clock.
// Shared between the host transmitter and the scan-code receiver.
//   clk_i        in   system clock
//   rst_ni       in   asynchronous active-low reset
//   ps2_clk_i    in   raw PS/2 clock pin
//   ps2_data_i   in   raw PS/2 data pin
//   clk_sync_o   out  synchronized PS/2 clock
//   data_sync_o  out  synchronized PS/2 data
//   clk_fall_o   out  one-cycle pulse on a synchronized clock falling edge
// ---------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [1:0] clkSync_q;
    logic [1:0] dataSync_q;
    logic       clkPrev_q;

    // Two-stage synchronizers plus a delayed copy of the synced clock.
    // Everything resets to 1 so an idle bus produces no spurious edge
    // when reset is released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    assign clk_sync_o  = clkSync_q[1];
    assign data_sync_o = dataSync_q[1];
    assign clk_fall_o  = clkPrev_q & ~clkSync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Takes a command byte over valid/ready,
// inhibits the bus clock, issues the start bit and then shifts 8 data bits
// (LSB first), odd parity and the stop bit on the device's falling clock
// edges, finally checking the device ACK. Lines are open-drain: the *_oe_o
// outputs pull the pins low when high.
//   clk_i          in   system clock
//   rst_ni         in   asynchronous active-low reset
//   data_i         in   command byte
//   valid_i        in   data_i valid
//   ready_o        out  idle and able to accept a byte
//   ps2_clk_i      in   raw PS/2 clock pin
//   ps2_data_i     in   raw PS/2 data pin
//   ps2_clk_oe_o   out  pull PS/2 clock low
//   ps2_data_oe_o  out  pull PS/2 data low
//   done_o         out  pulse: transfer completed with ACK
//   ack_err_o      out  pulse: device did not ACK
//   timeout_o      out  pulse: device stopped clocking, transfer aborted
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_DEFAULT_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic clkSync;
    logic dataSync;
    logic clkFall;

    ps2TxState_e       state_q,  state_d;
    logic [INH_W-1:0]  inhCnt_q, inhCnt_d;
    logic [TO_W-1:0]   toCnt_q,  toCnt_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [8:0]        frame_q,  frame_d;
    logic              ready_q,  ready_d;
    logic              clkOe_q,  clkOe_d;
    logic              dataOe_q, dataOe_d;
    logic              done_q,   done_d;
    logic              ackErr_q, ackErr_d;
    logic              timeout_q, timeout_d;

    ps2_sync_edge uSync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_sync_o  (clkSync),
        .data_sync_o (dataSync),
        .clk_fall_o  (clkFall)
    );

    // State register together with the datapath and every output flop.
    // Reset releases both lines at once and reports ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PS2_TX_IDLE;
            inhCnt_q  <= '0;
            toCnt_q   <= '0;
            bitCnt_q  <= '0;
            frame_q   <= '0;
            ready_q   <= 1'b1;
            clkOe_q   <= 1'b0;
            dataOe_q  <= 1'b0;
            done_q    <= 1'b0;
            ackErr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inhCnt_q  <= inhCnt_d;
            toCnt_q   <= toCnt_d;
            bitCnt_q  <= bitCnt_d;
            frame_q   <= frame_d;
            ready_q   <= ready_d;
            clkOe_q   <= clkOe_d;
            dataOe_q  <= dataOe_d;
            done_q    <= done_d;
            ackErr_q  <= ackErr_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic. The frame {parity, byte} is captured only on
    // accept and stays untouched until the next accept. While the device
    // owns the clock, a watchdog counts cycles since START entry or the
    // last falling edge; done has priority over a coincident timeout so
    // the status pulses stay mutually exclusive.
    always_comb begin
        state_d   = state_q;
        inhCnt_d  = inhCnt_q;
        toCnt_d   = toCnt_q;
        bitCnt_d  = bitCnt_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        ackErr_d  = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            PS2_TX_IDLE: begin
                if (valid_i && ready_q) begin
                    frame_d  = {ps2OddParity(data_i), data_i};
                    inhCnt_d = '0;
                    state_d  = PS2_TX_INHIBIT;
                end
            end

            PS2_TX_INHIBIT: begin
                if (inhCnt_q == INH_LAST) begin
                    toCnt_d = '0;
                    state_d = PS2_TX_START;
                end else begin
                    inhCnt_d = inhCnt_q + INH_W'(1);
                end
            end

            PS2_TX_START, PS2_TX_SHIFT, PS2_TX_WAIT_IDLE: begin
                if (clkFall) begin
                    toCnt_d = '0;
                end else if (toCnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = PS2_TX_IDLE;
                end else begin
                    toCnt_d = toCnt_q + TO_W'(1);
                end

                if (!timeout_d) begin
                    if (state_q == PS2_TX_START) begin
                        bitCnt_d = '0;
                        state_d  = PS2_TX_SHIFT;
                    end else if (state_q == PS2_TX_SHIFT) begin
                        if (clkFall) begin
                            bitCnt_d = bitCnt_q + 4'd1;
                            // 11th edge: device pulls data low to ACK
                            if (bitCnt_q == 4'd10) begin
                                if (dataSync) begin
                                    ackErr_d = 1'b1;
                                    state_d  = PS2_TX_IDLE;
                                end else begin
                                    state_d  = PS2_TX_WAIT_IDLE;
                                end
                            end
                        end
                    end else begin
                        if (clkSync && dataSync) begin
                            done_d  = 1'b1;
                            state_d = PS2_TX_IDLE;
                        end
                    end
                end else if (state_q == PS2_TX_WAIT_IDLE && clkSync && dataSync) begin
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d = PS2_TX_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    // Bit count 0 keeps the start bit on the wire, 1..9 carry data then
    // parity (pull low for a 0), 10 and beyond release the line (stop bit).
    // ready stays low during the status pulse cycle.
    always_comb begin
        clkOe_d  = (state_d == PS2_TX_INHIBIT);
        dataOe_d = 1'b0;
        ready_d  = (state_d == PS2_TX_IDLE) && !(done_d || ackErr_d || timeout_d);

        case (state_d)
            PS2_TX_START: begin
                dataOe_d = 1'b1;
            end
            PS2_TX_SHIFT: begin
                if (bitCnt_d == 4'd0) begin
                    dataOe_d = 1'b1;
                end else if (bitCnt_d <= 4'd9) begin
                    dataOe_d = ~frame_d[bitCnt_d - 4'd1];
                end
            end
            default: begin
                dataOe_d = 1'b0;
            end
        endcase
    end

    assign ready_o       = ready_q;
    assign ps2_clk_oe_o  = clkOe_q;
    assign ps2_data_oe_o = dataOe_q;
    assign done_o        = done_q;
    assign ack_err_o     = ackErr_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a PS/2 device model on open-drain wires. The
// expected wire sequence for each byte is built from the protocol rules:
// start 0, data LSB first, odd parity, stop 1.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TO   = 300;
    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       ready, clkOe, dataOe, done, ackErr, timeoutP;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;
    logic       ps2Clk, ps2Data;

    int total = 0;
    int bad = 0;
    int doneCnt = 0;
    int ackErrCnt = 0;
    int timeoutCnt = 0;
    logic wbit [0:10];

    // Open-drain bus: either side may pull a line low
    assign ps2Clk  = ~(clkOe | devClkLow);
    assign ps2Data = ~(dataOe | devDataLow);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_i        (dataIn),
        .valid_i       (validIn),
        .ready_o       (ready),
        .ps2_clk_i     (ps2Clk),
        .ps2_data_i    (ps2Data),
        .ps2_clk_oe_o  (clkOe),
        .ps2_data_oe_o (dataOe),
        .done_o        (done),
        .ack_err_o     (ackErr),
        .timeout_o     (timeoutP)
    );

    // Count status pulses as the cycle carrying them ends
    always @(posedge clk) begin
        if (done)     doneCnt++;
        if (ackErr)   ackErrCnt++;
        if (timeoutP) timeoutCnt++;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return done;
            1:       return ackErr;
            default: return timeoutP;
        endcase
    endfunction

    // Expected wire bits for a byte, straight from the frame format
    task automatic buildWire(input logic [7:0] b);
        wbit[0] = 1'b0;
        for (int i = 0; i < 8; i++) wbit[i+1] = b[i];
        wbit[9]  = ($countones(b) % 2 == 0);
        wbit[10] = 1'b1;
    endtask

    // Handshake one byte and check the inhibit window timing
    task automatic doAccept(input logic [7:0] b);
        int waited = 0;
        while (!ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready before accept", ready, 1);
        dataIn  = b;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        dataIn  = 8'($urandom_range(0, 255));
        checkOutput("accept ready low", ready, 0);
        checkOutput("accept clk inhibit", clkOe, 1);
        checkOutput("accept data released", dataOe, 0);
        repeat (INH - 1) @(negedge clk);
        checkOutput("inhibit last clkoe", clkOe, 1);
        checkOutput("inhibit last dataoe", dataOe, 0);
        @(negedge clk);
        checkOutput("start clkoe", clkOe, 0);
        checkOutput("start dataoe", dataOe, 1);
    endtask

    // Device generates nEdges clock pulses and samples data on each rise
    task automatic runDevice(input int nEdges, input bit inject);
        for (int e = 1; e <= nEdges; e++) begin
            if (inject && e == 5) begin
                repeat (2) @(negedge clk);
                validIn = 1'b1;
                dataIn  = 8'h55;
                checkOutput("busy ready", ready, 0);
                @(negedge clk);
                validIn = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            devClkLow = 1'b1;
            repeat (2) @(negedge clk);
            checkOutput($sformatf("edge%0d hold", e), dataOe, !wbit[e-1]);
            @(negedge clk);
            checkOutput($sformatf("edge%0d update", e), dataOe, !wbit[e]);
            checkOutput($sformatf("edge%0d clkoe", e), clkOe, 0);
            repeat (HALF - 3) @(negedge clk);
            checkOutput($sformatf("wire bit%0d", e), ps2Data, wbit[e]);
            devClkLow = 1'b0;
        end
    endtask

    // Bounded wait for a status pulse, then check its shape
    task automatic waitPulse(input int which, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = sel(which);
        end
        checkOutput({tag, " seen"}, seen, 1);
        if (seen) begin
            checkOutput({tag, " exclusive"}, int'(done) + int'(ackErr) + int'(timeoutP), 1);
            checkOutput({tag, " ready in pulse"}, ready, 0);
            checkOutput({tag, " clkoe"}, clkOe, 0);
            checkOutput({tag, " dataoe"}, dataOe, 0);
            @(negedge clk);
            checkOutput({tag, " width"}, sel(which), 0);
            checkOutput({tag, " ready after"}, ready, 1);
        end
    endtask

    // One complete transfer with an optional device ACK
    task automatic applyStimulus(input logic [7:0] b, input bit giveAck, input bit inject);
        int doneB = doneCnt;
        int ackB  = ackErrCnt;
        buildWire(b);
        doAccept(b);
        runDevice(10, inject);
        if (giveAck) devDataLow = 1'b1;
        repeat (HALF) @(negedge clk);
        devClkLow = 1'b1;
        if (giveAck) begin
            repeat (HALF) @(negedge clk);
            devClkLow  = 1'b0;
            devDataLow = 1'b0;
            waitPulse(0, "done");
        end else begin
            waitPulse(1, "ackerr");
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
        end
        repeat (5) @(negedge clk);
        checkOutput("done count", doneCnt, doneB + (giveAck ? 1 : 0));
        checkOutput("ackerr count", ackErrCnt, ackB + (giveAck ? 0 : 1));
    endtask

    initial begin
        int k;
        int doneB;
        logic [7:0] rb;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("reset ready", ready, 1);
        checkOutput("reset clkoe", clkOe, 0);
        checkOutput("reset dataoe", dataOe, 0);
        checkOutput("reset pulses", {done, ackErr, timeoutP}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed bytes");
        applyStimulus(PS2_CMD_SET_LEDS, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);

        $display("[TB] random bytes");
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(rb, 1'b1, 1'b0);
        end

        $display("[TB] missing ack");
        rb = 8'($urandom_range(0, 255));
        applyStimulus(rb, 1'b0, 1'b0);

        $display("[TB] timeout");
        buildWire(8'h5A);
        doAccept(8'h5A);
        k = 0;
        while (!timeoutP && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("timeout latency", k, TO);
        checkOutput("timeout clkoe", clkOe, 0);
        checkOutput("timeout dataoe", dataOe, 0);
        @(negedge clk);
        checkOutput("timeout width", timeoutP, 0);
        checkOutput("timeout ready after", ready, 1);
        checkOutput("timeout count", timeoutCnt, 1);

        $display("[TB] reset mid-transfer");
        doneB = doneCnt;
        buildWire(8'hA7);
        doAccept(8'hA7);
        runDevice(5, 1'b0);
        checkOutput("pre-reset dataoe", dataOe, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset dataoe", dataOe, 0);
        checkOutput("async reset clkoe", clkOe, 0);
        checkOutput("async reset ready", ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no pulse after reset", doneCnt, doneB);
        applyStimulus(PS2_CMD_ENABLE, 1'b1, 1'b0);

        $display("[TB] valid ignored while busy");
        applyStimulus(PS2_CMD_RESET, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("no queued transfer", clkOe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
